// File: rtl/ifetch_unit.sv
// ifetch_unit: holds the fetch PC, issues one-word read requests to memory
// port 0 and buffers returned {pc, word} pairs in a small prefetch FIFO that
// the decode stage drains with valid/ready. Redirects flush the FIFO and
// discard any responses still in flight.
module ifetch_unit #(
  parameter int                    ADDR_WIDTH = 16,
  parameter int                    DATA_WIDTH = 16,
  parameter int                    DEPTH      = 4,
  parameter logic [ADDR_WIDTH-1:0] RESET_PC   = '0
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  fetch_en,
  input  logic                  redirect_valid,
  input  logic [ADDR_WIDTH-1:0] redirect_pc,
  output logic                  mem_req,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  input  logic                  mem_ack,
  input  logic [DATA_WIDTH-1:0] mem_data,
  output logic                  instr_valid,
  output logic [DATA_WIDTH-1:0] instr_data,
  output logic [ADDR_WIDTH-1:0] instr_pc,
  input  logic                  instr_ready,
  output logic                  protocol_err
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = PW + 1;

  // Control state
  logic [ADDR_WIDTH-1:0] r_fetch_pc;
  logic [ADDR_WIDTH-1:0] r_mem_addr;
  logic                  r_mem_req;
  logic [PW-1:0]         r_rd_ptr;
  logic [PW-1:0]         r_wr_ptr;
  logic [CW-1:0]         r_count;
  logic [CW-1:0]         r_pending;
  logic [CW-1:0]         r_discard;
  logic                  r_perr;
  logic                  r_rst_d;

  // FIFO storage (data only, never reset; outputs are gated by r_count)
  logic [ADDR_WIDTH-1:0] r_fifo_pc   [DEPTH];
  logic [DATA_WIDTH-1:0] r_fifo_data [DEPTH];

  logic                  w_ack_live;
  logic                  w_ack_ok;
  logic                  w_spurious;
  logic                  w_push;
  logic                  w_pop;
  logic                  w_issue;
  logic [CW-1:0]         w_pending_base;
  logic [CW-1:0]         w_pending_next;
  logic [CW-1:0]         w_count_next;
  logic [CW-1:0]         w_discard_next;
  logic [CW:0]           w_occ;
  logic [ADDR_WIDTH-1:0] w_ack_pc;

  // Next-state: ack accounting, push/pop, slot-guaranteed issue decision
  always_comb begin
    // An ack in the cycle right after reset belongs to a pre-reset request.
    w_ack_live     = mem_ack & ~r_rst_d;
    w_ack_ok       = w_ack_live & (r_pending != '0);
    w_spurious     = w_ack_live & (r_pending == '0);
    w_push         = w_ack_ok & (r_discard == '0) & ~redirect_valid;
    w_pop          = (r_count != '0) & instr_ready & ~redirect_valid;
    w_pending_base = r_pending - CW'(w_ack_ok);
    w_count_next   = redirect_valid ? '0 : (r_count + CW'(w_push) - CW'(w_pop));
    // Issue only when every outstanding response plus this one has a slot.
    w_occ          = {1'b0, w_count_next} + {1'b0, w_pending_base};
    w_issue        = fetch_en & ~redirect_valid & (w_occ < (CW+1)'(DEPTH));
    w_pending_next = w_pending_base + CW'(w_issue);
    w_discard_next = r_discard;
    if (redirect_valid) begin
      // Everything still unacked after this edge belongs to the old stream.
      w_discard_next = w_pending_base;
    end else if (w_ack_ok && (r_discard != '0)) begin
      w_discard_next = r_discard - CW'(1);
    end
    // Kept responses are contiguous and end at fetch_pc-1, so the oldest
    // outstanding address is fetch_pc minus the number outstanding.
    w_ack_pc       = r_fetch_pc - ADDR_WIDTH'(r_pending);
  end

  // Control registers: PC, request port, FIFO pointers, counters, error flag
  always_ff @(posedge clk) begin
    if (rst) begin
      r_fetch_pc <= RESET_PC;
      r_mem_req  <= 1'b0;
      r_mem_addr <= '0;
      r_rd_ptr   <= '0;
      r_wr_ptr   <= '0;
      r_count    <= '0;
      r_pending  <= '0;
      r_discard  <= '0;
      r_perr     <= 1'b0;
      r_rst_d    <= 1'b1;
    end else begin
      r_rst_d   <= 1'b0;
      r_mem_req <= w_issue;
      if (w_issue) begin
        r_mem_addr <= r_fetch_pc;
        r_fetch_pc <= r_fetch_pc + ADDR_WIDTH'(1);
      end else if (redirect_valid) begin
        r_fetch_pc <= redirect_pc;
      end
      if (redirect_valid) begin
        r_rd_ptr <= '0;
        r_wr_ptr <= '0;
      end else begin
        if (w_push) r_wr_ptr <= r_wr_ptr + PW'(1);
        if (w_pop)  r_rd_ptr <= r_rd_ptr + PW'(1);
      end
      r_count   <= w_count_next;
      r_pending <= w_pending_next;
      r_discard <= w_discard_next;
      if (w_spurious) r_perr <= 1'b1;
    end
  end

  // FIFO write port: record the returned word with the address it came from
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_fifo_pc[r_wr_ptr]   <= w_ack_pc;
      r_fifo_data[r_wr_ptr] <= mem_data;
    end
  end

  assign mem_req      = r_mem_req;
  assign mem_addr     = r_mem_addr;
  assign instr_valid  = (r_count != '0);
  assign instr_pc     = instr_valid ? r_fifo_pc[r_rd_ptr]   : '0;
  assign instr_data   = instr_valid ? r_fifo_data[r_rd_ptr] : '0;
  assign protocol_err = r_perr;

endmodule

// File: tb/tb_ifetch_unit.sv
// tb_ifetch_unit: drives ifetch_unit with a one-cycle-latency memory model
// (word = addr ^ 0xA5A5) and checks delivered instructions against the
// expected sequential program stream, restarted at every redirect.
module tb_ifetch_unit;

  localparam int          DEPTH = 4;
  localparam logic [15:0] RPC   = 16'h0010;
  localparam logic [15:0] XMASK = 16'hA5A5;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        fetch_en = 1'b0;
  logic        redirect_valid = 1'b0;
  logic [15:0] redirect_pc = '0;
  logic        mem_req;
  logic [15:0] mem_addr;
  logic        mem_ack = 1'b0;
  logic [15:0] mem_data = '0;
  logic        instr_valid;
  logic [15:0] instr_data;
  logic [15:0] instr_pc;
  logic        instr_ready = 1'b0;
  logic        protocol_err;

  int          total = 0;
  int          bad = 0;
  int          npop = 0;
  logic [15:0] exp_pc = RPC;
  logic [15:0] exp_req = RPC;
  logic        req_d = 1'b0;
  logic [15:0] addr_d = '0;
  logic        inj = 1'b0;

  ifetch_unit #(
    .ADDR_WIDTH(16),
    .DATA_WIDTH(16),
    .DEPTH     (DEPTH),
    .RESET_PC  (RPC)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .fetch_en      (fetch_en),
    .redirect_valid(redirect_valid),
    .redirect_pc   (redirect_pc),
    .mem_req       (mem_req),
    .mem_addr      (mem_addr),
    .mem_ack       (mem_ack),
    .mem_data      (mem_data),
    .instr_valid   (instr_valid),
    .instr_data    (instr_data),
    .instr_pc      (instr_pc),
    .instr_ready   (instr_ready),
    .protocol_err  (protocol_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s: got %h want %h", tag, got, want);
    end
  endtask

  // One clock: score the pop that this edge performs, advance, then play the
  // memory and check the request stream.
  task automatic tick();
    if (!rst && !redirect_valid && instr_valid === 1'b1 && instr_ready) begin
      chk("pop_pc", 32'(instr_pc), 32'(exp_pc));
      chk("pop_data", 32'(instr_data), 32'(exp_pc ^ XMASK));
      exp_pc = exp_pc + 16'd1;
      npop++;
    end
    @(posedge clk);
    #1;
    mem_ack  = req_d | inj;
    mem_data = req_d ? (addr_d ^ XMASK) : 16'($urandom);
    inj      = 1'b0;
    req_d    = (mem_req === 1'b1);
    addr_d   = mem_addr;
    if (rst) begin
      exp_pc  = RPC;
      exp_req = RPC;
    end else if (redirect_valid) begin
      chk("redir_noreq", 32'(mem_req), 32'd0);
      exp_pc  = redirect_pc;
      exp_req = redirect_pc;
    end else begin
      if (!fetch_en) chk("hold_noreq", 32'(mem_req), 32'd0);
      if (mem_req === 1'b1) begin
        chk("req_addr", 32'(mem_addr), 32'(exp_req));
        exp_req = exp_req + 16'd1;
      end
    end
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_req"},   32'(mem_req), 32'd0);
    chk({tag, "_addr"},  32'(mem_addr), 32'd0);
    chk({tag, "_valid"}, 32'(instr_valid), 32'd0);
    chk({tag, "_data"},  32'(instr_data), 32'd0);
    chk({tag, "_pc"},    32'(instr_pc), 32'd0);
    chk({tag, "_perr"},  32'(protocol_err), 32'd0);
  endtask

  initial begin
    int n;
    // Reset and first-fetch latency
    rst = 1'b1; fetch_en = 1'b1; instr_ready = 1'b1;
    repeat (3) tick();
    chk_all_zero("rst");
    rst = 1'b0;
    tick();
    chk("e0_req", 32'(mem_req), 32'd1);
    chk("e0_addr", 32'(mem_addr), 32'(RPC));
    chk("e0_valid", 32'(instr_valid), 32'd0);
    tick();
    chk("e1_valid", 32'(instr_valid), 32'd0);
    tick();
    chk("e2_valid", 32'(instr_valid), 32'd1);
    chk("e2_pc", 32'(instr_pc), 32'(RPC));
    repeat (8) begin
      tick();
      chk("steady_valid", 32'(instr_valid), 32'd1);
      chk("steady_req", 32'(mem_req), 32'd1);
    end

    // Backpressure: fill up, then drain with fetching paused
    instr_ready = 1'b0;
    repeat (10) tick();
    chk("bp_req_stop", 32'(mem_req), 32'd0);
    chk("bp_valid", 32'(instr_valid), 32'd1);
    fetch_en = 1'b0; instr_ready = 1'b1; n = 0;
    for (int i = 0; i < 10 && instr_valid === 1'b1; i++) begin
      n++;
      tick();
    end
    chk("bp_depth", 32'(n), 32'(DEPTH));
    fetch_en = 1'b1;
    repeat (12) tick();

    // Redirect with two requests in flight, coincident with ack and pop
    chk("pre_redir_req", 32'(mem_req), 32'd1);
    chk("pre_redir_valid", 32'(instr_valid), 32'd1);
    redirect_valid = 1'b1; redirect_pc = 16'h0200;
    tick();
    redirect_valid = 1'b0;
    chk("redir_empty", 32'(instr_valid), 32'd0);
    tick();
    chk("r1_req", 32'(mem_req), 32'd1);
    chk("r1_addr", 32'(mem_addr), 32'h0200);
    chk("r1_valid", 32'(instr_valid), 32'd0);
    tick();
    chk("r2_valid", 32'(instr_valid), 32'd0);
    tick();
    chk("r3_valid", 32'(instr_valid), 32'd1);
    chk("r3_pc", 32'(instr_pc), 32'h0200);
    chk("redir_perr", 32'(protocol_err), 32'd0);
    repeat (4) tick();

    // PC wrap through 0xFFFF
    redirect_valid = 1'b1; redirect_pc = 16'hFFFE;
    tick();
    redirect_valid = 1'b0;
    repeat (3) tick();
    chk("wrap0", 32'(instr_pc), 32'hFFFE);
    tick();
    chk("wrap1", 32'(instr_pc), 32'hFFFF);
    tick();
    chk("wrap2", 32'(instr_pc), 32'h0000);
    tick();
    chk("wrap3", 32'(instr_pc), 32'h0001);
    repeat (3) tick();

    // Randomized enable / ready / redirect traffic
    npop = 0;
    for (int i = 0; i < 600; i++) begin
      fetch_en       = ($urandom_range(0, 9) < 8);
      instr_ready    = ($urandom_range(0, 9) < 7);
      redirect_valid = ($urandom_range(0, 29) == 0);
      redirect_pc    = 16'($urandom);
      tick();
    end
    redirect_valid = 1'b0;
    chk("rand_progress", 32'(npop > 100), 32'd1);

    // Spurious ack with nothing outstanding; flag is sticky
    fetch_en = 1'b0; instr_ready = 1'b1;
    repeat (6) tick();
    chk("perr_before", 32'(protocol_err), 32'd0);
    inj = 1'b1;
    tick();
    tick();
    chk("perr_set", 32'(protocol_err), 32'd1);
    fetch_en = 1'b1;
    repeat (5) tick();
    chk("perr_sticky", 32'(protocol_err), 32'd1);
    chk("burst_req", 32'(mem_req), 32'd1);

    // Reset mid-burst; the stale ack right after reset is ignored
    rst = 1'b1;
    tick();
    chk_all_zero("midrst");
    rst = 1'b0;
    tick();
    chk("post_rst_perr", 32'(protocol_err), 32'd0);
    chk("post_rst_req", 32'(mem_req), 32'd1);
    chk("post_rst_addr", 32'(mem_addr), 32'(RPC));
    repeat (6) tick();
    chk("final_perr", 32'(protocol_err), 32'd0);
    chk("final_valid", 32'(instr_valid), 32'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
